param_up_down_counter: RTL and testbench
========================================

// Module: param_up_down_counter
// PURPOSE
//   Parametrised up/down counter; next generation of the lab's 16-bit up/down counter.
//   Adds configurable width and modulus, wrap or saturate mode, and a variable step.
//   Also adds count enable, synchronous clear, parallel load, and registered
//   overflow/underflow flags (pulse and sticky).
//   Used as a general event/position counter in datapath and timer blocks.
// PARAMETERS
//   WIDTH    16            counter width in bits (>= 2)
//   MAX_VAL  2**WIDTH-1    top count; counter range is 0..MAX_VAL (modulus MAX_VAL+1)
//   SATURATE 0             0 = wrap modulo MAX_VAL+1, 1 = clamp at 0 / MAX_VAL
//   STEP_W   4             width of step input; 2**STEP_W-1 <= MAX_VAL required
// PORTS
//   clk       in   1        rising-edge clock
//   reset     in   1        asynchronous, active-low reset (0 = reset asserted)
//   en        in   1        count enable
//   clr       in   1        synchronous clear to 0 (also clears sticky flags)
//   load      in   1        synchronous parallel load
//   load_val  in   WIDTH    value loaded when load=1
//   up_down   in   1        1 = count up, 0 = count down
//   step      in   STEP_W   increment/decrement magnitude; 0 = hold
//   out       out  WIDTH    registered count
//   at_max    out  1        combinational: out == MAX_VAL
//   at_min    out  1        combinational: out == 0
//   ovf_p     out  1        registered 1-cycle pulse: up-count crossed MAX_VAL
//   unf_p     out  1        registered 1-cycle pulse: down-count crossed 0
//   ovf_stk   out  1        sticky overflow; set with ovf_p, cleared by clr/reset
//   unf_stk   out  1        sticky underflow; set with unf_p, cleared by clr/reset
// BEHAVIOUR
//   - reset=0 (async, any time): out=0, ovf_p=unf_p=0, ovf_stk=unf_stk=0 immediately.
//   - Release is sampled synchronously; first update on the first clk edge with reset=1.
//   - Priority per edge: clr > load > en-count > hold.
//   - clr=1: out<=0, all flags<=0; load, en, step ignored.
//   - load=1: out<=min(load_val, MAX_VAL); ovf_p/unf_p<=0; sticky flags unchanged.
//   - en=1, up_down=1: s = out + step, computed WIDTH+1 bits wide.
//     - s <= MAX_VAL: out<=s.
//     - s > MAX_VAL, wrap mode: out<=s-(MAX_VAL+1), ovf_p<=1.
//     - s > MAX_VAL, saturate mode: out<=MAX_VAL, ovf_p<=1.
//   - en=1, up_down=0:
//     - step <= out: out<=out-step.
//     - step > out, wrap mode: out<=out+(MAX_VAL+1)-step, unf_p<=1.
//     - step > out, saturate mode: out<=0, unf_p<=1.
//   - Saturate mode at the limit: pulse fires on every enabled attempt to pass it, even
//     though out holds (e.g. at MAX_VAL with step>0).
//   - step=0 or en=0: out holds, ovf_p/unf_p<=0.
//   - Pulses are valid the cycle after the causing edge; the new out appears on the same edge.
//   - ovf_stk/unf_stk <= stk | pulse condition; only clr or reset clears them.
//   - Latency: 1 clk from inputs to out/flags; at_max/at_min follow out combinationally.
//   - Reset mid-count: abandons the operation; no pulse is emitted for the interrupted cycle.
//   - MAX_VAL = 2**WIDTH-1: behaviour is identical to natural binary wrap.
// TESTING
//   1 Reset: drive reset=0 mid-count at out=0x1234 -> out=0, all flags 0 before next edge.
//   2 Wrap up: WIDTH=4, MAX_VAL=9, SATURATE=0, out=8, step=3, en=1, up -> out=1, ovf_p=1
//     one cycle, ovf_stk=1.
//   3 Wrap down: same config, out=1, step=3, down -> out=8, unf_p=1.
//     Then step=0 -> out=8, unf_p=0, unf_stk=1.
//   4 Saturate: SATURATE=1, MAX_VAL=9, out=7, step=5 up -> out=9, ovf_p=1.
//     Next edge step=1 -> out=9, ovf_p=1 again, at_max=1.
//   5 Priority: clr=1, load=1, load_val=5, en=1 in the same cycle -> out=0, stickies 0.
//     Then load=1, en=1, load_val=12 (MAX_VAL=9) -> out=9, no pulse.
//   6 Default 16-bit: out=0xFFFF, step=1 up -> out=0x0000, ovf_p=1.
//     Then step=1 down -> out=0xFFFF, unf_p=1.

Source files
------------

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with configurable modulus, wrap or saturate behaviour,
// variable step, sync clear/load and registered overflow/underflow pulse + sticky flags.
module param_up_down_counter #(
  parameter int unsigned      WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0,
  parameter int unsigned      STEP_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              up_down_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              at_max_o,
  output logic              at_min_o,
  output logic              ovf_p_o,
  output logic              unf_p_o,
  output logic              ovf_stk_o,
  output logic              unf_stk_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_p_q, ovf_p_d;
  logic             unf_p_q, unf_p_d;
  logic             ovf_stk_q, ovf_stk_d;
  logic             unf_stk_q, unf_stk_d;

  // All arithmetic is done one bit wider so that the crossing of MAX_VAL / 0 is visible.
  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] max_ext;
  logic [WIDTH:0] mod_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] diff_dn;
  logic [WIDTH:0] wrap_dn;
  logic           over_up;
  logic           under_dn;
  logic           step_nz;

  assign cnt_ext  = {1'b0, cnt_q};
  assign max_ext  = {1'b0, MAX_VAL};
  assign mod_ext  = max_ext + 1'b1;
  assign step_ext = (WIDTH+1)'(step_i);
  assign step_nz  = |step_i;

  assign sum_up   = cnt_ext + step_ext;
  assign over_up  = sum_up > max_ext;
  assign diff_dn  = cnt_ext - step_ext;
  // Only used when step > count, so the result is always below the modulus.
  assign wrap_dn  = cnt_ext + mod_ext - step_ext;
  assign under_dn = step_ext > cnt_ext;

  always_comb begin
    cnt_d     = cnt_q;
    ovf_p_d   = 1'b0;
    unf_p_d   = 1'b0;
    ovf_stk_d = ovf_stk_q;
    unf_stk_d = unf_stk_q;

    if (clr_i) begin
      cnt_d     = '0;
      ovf_stk_d = 1'b0;
      unf_stk_d = 1'b0;
    end else if (load_i) begin
      cnt_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
    end else if (en_i && step_nz) begin
      if (up_down_i) begin
        if (over_up) begin
          ovf_p_d = 1'b1;
          cnt_d   = SATURATE ? MAX_VAL : WIDTH'(sum_up - mod_ext);
        end else begin
          cnt_d = WIDTH'(sum_up);
        end
      end else begin
        if (under_dn) begin
          unf_p_d = 1'b1;
          cnt_d   = SATURATE ? '0 : WIDTH'(wrap_dn);
        end else begin
          cnt_d = WIDTH'(diff_dn);
        end
      end
      ovf_stk_d = ovf_stk_q | ovf_p_d;
      unf_stk_d = unf_stk_q | unf_p_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      ovf_p_q   <= 1'b0;
      unf_p_q   <= 1'b0;
      ovf_stk_q <= 1'b0;
      unf_stk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ovf_p_q   <= ovf_p_d;
      unf_p_q   <= unf_p_d;
      ovf_stk_q <= ovf_stk_d;
      unf_stk_q <= unf_stk_d;
    end
  end

  assign out_o     = cnt_q;
  assign at_max_o  = (cnt_q == MAX_VAL);
  assign at_min_o  = (cnt_q == '0);
  assign ovf_p_o   = ovf_p_q;
  assign unf_p_o   = unf_p_q;
  assign ovf_stk_o = ovf_stk_q;
  assign unf_stk_o = unf_stk_q;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Bench for param_up_down_counter: three configurations (16-bit wrap, mod-10 wrap,
// mod-10 saturate) driven in lockstep and compared against an arithmetic reference model.
module tb_param_up_down_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, load = 1'b0, up_down = 1'b0;
  logic [15:0] load_val = '0;
  logic [3:0]  step = '0;

  logic [15:0] out0;
  logic [3:0]  out1, out2;
  logic [2:0]  o_atmax, o_atmin, o_ovfp, o_unfp, o_ovfs, o_unfs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_up_down_counter u_d16 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load),
    .load_val_i(load_val), .up_down_i(up_down), .step_i(step),
    .out_o(out0), .at_max_o(o_atmax[0]), .at_min_o(o_atmin[0]), .ovf_p_o(o_ovfp[0]),
    .unf_p_o(o_unfp[0]), .ovf_stk_o(o_ovfs[0]), .unf_stk_o(o_unfs[0])
  );

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0), .STEP_W(3)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load),
    .load_val_i(load_val[3:0]), .up_down_i(up_down), .step_i(step[2:0]),
    .out_o(out1), .at_max_o(o_atmax[1]), .at_min_o(o_atmin[1]), .ovf_p_o(o_ovfp[1]),
    .unf_p_o(o_unfp[1]), .ovf_stk_o(o_ovfs[1]), .unf_stk_o(o_unfs[1])
  );

  param_up_down_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1), .STEP_W(3)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .load_i(load),
    .load_val_i(load_val[3:0]), .up_down_i(up_down), .step_i(step[2:0]),
    .out_o(out2), .at_max_o(o_atmax[2]), .at_min_o(o_atmin[2]), .ovf_p_o(o_ovfp[2]),
    .unf_p_o(o_unfp[2]), .ovf_stk_o(o_ovfs[2]), .unf_stk_o(o_unfs[2])
  );

  // Reference model state, one entry per instance.
  longint m_cnt[3];
  bit     m_op[3], m_up[3], m_os[3], m_us[3];
  longint mx[3]     = '{65535, 9, 9};
  bit     sat[3]    = '{1'b0, 1'b0, 1'b1};
  longint lv_mask[3] = '{65535, 15, 15};
  longint st_mask[3] = '{15, 7, 7};

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint obs_out(input int i);
    case (i)
      0:       return longint'(out0);
      1:       return longint'(out1);
      default: return longint'(out2);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_op[i] = 0; m_up[i] = 0; m_os[i] = 0; m_us[i] = 0;
    end
  endtask

  // One clock edge of behaviour, straight from the counter's arithmetic rules.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      longint lv = longint'(load_val) & lv_mask[i];
      longint st = longint'(step) & st_mask[i];
      m_op[i] = 0;
      m_up[i] = 0;
      if (clr) begin
        m_cnt[i] = 0; m_os[i] = 0; m_us[i] = 0;
      end else if (load) begin
        m_cnt[i] = (lv > mx[i]) ? mx[i] : lv;
      end else if (en && st != 0) begin
        if (up_down) begin
          longint s = m_cnt[i] + st;
          if (s > mx[i]) begin
            m_op[i] = 1;
            m_cnt[i] = sat[i] ? mx[i] : s - (mx[i] + 1);
          end else m_cnt[i] = s;
        end else begin
          if (st > m_cnt[i]) begin
            m_up[i] = 1;
            m_cnt[i] = sat[i] ? 0 : m_cnt[i] + mx[i] + 1 - st;
          end else m_cnt[i] = m_cnt[i] - st;
        end
        m_os[i] |= m_op[i];
        m_us[i] |= m_up[i];
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s.d%0d.out", tag, i), obs_out(i), m_cnt[i]);
      check_eq($sformatf("%s.d%0d.at_max", tag, i), longint'(o_atmax[i]),
               longint'(m_cnt[i] == mx[i]));
      check_eq($sformatf("%s.d%0d.at_min", tag, i), longint'(o_atmin[i]),
               longint'(m_cnt[i] == 0));
      check_eq($sformatf("%s.d%0d.ovf_p", tag, i), longint'(o_ovfp[i]), longint'(m_op[i]));
      check_eq($sformatf("%s.d%0d.unf_p", tag, i), longint'(o_unfp[i]), longint'(m_up[i]));
      check_eq($sformatf("%s.d%0d.ovf_stk", tag, i), longint'(o_ovfs[i]), longint'(m_os[i]));
      check_eq($sformatf("%s.d%0d.unf_stk", tag, i), longint'(o_unfs[i]), longint'(m_us[i]));
    end
  endtask

  // Apply the current inputs on one rising edge, then check just after it.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic c, input logic l, input logic [15:0] lv, input logic e,
                        input logic ud, input logic [3:0] s);
    clr = c; load = l; load_val = lv; en = e; up_down = ud; step = s;
  endtask

  // Asynchronous reset placed between edges; checked before the next edge arrives.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #5;
    rst_n = 1'b1;

    // Reset mid-count at 0x1234.
    set_in(0, 1, 16'h1234, 0, 1, 0); tick("ld1234");
    check_eq("ld1234.out", longint'(out0), 64'h1234);
    set_in(0, 0, 16'h0, 1, 1, 3);
    async_reset("rst_mid");
    check_eq("rst_mid.out", longint'(out0), 0);

    // Wrap up on mod-10.
    set_in(0, 1, 16'd8, 0, 1, 0); tick("ld8");
    set_in(0, 0, 16'd0, 1, 1, 3); tick("wrap_up");
    check_eq("wrap_up.out", longint'(out1), 1);
    check_eq("wrap_up.ovf_p", longint'(o_ovfp[1]), 1);
    check_eq("wrap_up.ovf_stk", longint'(o_ovfs[1]), 1);
    set_in(0, 0, 16'd0, 0, 1, 3); tick("wrap_up_hold");
    check_eq("wrap_up_hold.ovf_p", longint'(o_ovfp[1]), 0);

    // Wrap down on mod-10, then step=0 hold.
    set_in(0, 1, 16'd1, 0, 1, 0); tick("ld1");
    set_in(0, 0, 16'd0, 1, 0, 3); tick("wrap_dn");
    check_eq("wrap_dn.out", longint'(out1), 8);
    check_eq("wrap_dn.unf_p", longint'(o_unfp[1]), 1);
    set_in(0, 0, 16'd0, 1, 0, 0); tick("wrap_dn_s0");
    check_eq("wrap_dn_s0.out", longint'(out1), 8);
    check_eq("wrap_dn_s0.unf_p", longint'(o_unfp[1]), 0);
    check_eq("wrap_dn_s0.unf_stk", longint'(o_unfs[1]), 1);

    // Saturate at MAX_VAL, pulse repeats while clamped.
    set_in(0, 1, 16'd7, 0, 1, 0); tick("ld7");
    set_in(0, 0, 16'd0, 1, 1, 5); tick("sat_up");
    check_eq("sat_up.out", longint'(out2), 9);
    check_eq("sat_up.ovf_p", longint'(o_ovfp[2]), 1);
    set_in(0, 0, 16'd0, 1, 1, 1); tick("sat_again");
    check_eq("sat_again.out", longint'(out2), 9);
    check_eq("sat_again.ovf_p", longint'(o_ovfp[2]), 1);
    check_eq("sat_again.at_max", longint'(o_atmax[2]), 1);

    // Priority clr > load > en, then clamped load.
    set_in(1, 1, 16'd5, 1, 1, 1); tick("prio_clr");
    check_eq("prio_clr.out", longint'(out1), 0);
    check_eq("prio_clr.stk", longint'({o_ovfs, o_unfs}), 0);
    set_in(0, 1, 16'd12, 1, 1, 1); tick("prio_ld");
    check_eq("prio_ld.out", longint'(out1), 9);
    check_eq("prio_ld.ovf_p", longint'(o_ovfp[1]), 0);

    // 16-bit natural wrap in both directions.
    set_in(0, 1, 16'hFFFF, 0, 1, 0); tick("ldffff");
    set_in(0, 0, 16'h0, 1, 1, 1); tick("d16_up");
    check_eq("d16_up.out", longint'(out0), 0);
    check_eq("d16_up.ovf_p", longint'(o_ovfp[0]), 1);
    set_in(0, 0, 16'h0, 1, 0, 1); tick("d16_dn");
    check_eq("d16_dn.out", longint'(out0), 64'hFFFF);
    check_eq("d16_dn.unf_p", longint'(o_unfp[0]), 1);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [15:0] lv;
      lv = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      set_in(logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 9) == 0), lv,
             logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      else tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
